rn_inject_arb: RTL and testbench

RN_INJECT_ARB -- requirements
Module: rn_inject_arb

---
 rtl/rn_inject_arb.sv | 198 +++++++++++++++++++
 tb/tb_rn_inject_arb.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rn_inject_arb.sv
// rn_inject_arb
//   Merges the AW, W and AR request channels of an RN wrapper onto the single
//   local injection port of a router. Single-flit AW/AR packets and
//   multi-flit W packets share one output register. A W packet is never
//   interleaved with other traffic once its head flit is accepted. W heads
//   are only admitted when an AW is outstanding.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | between packets; round-robin AW -> W -> AR over eligible heads
//   WLOCK | multi-flit W packet in flight; only W flits accepted until tail
//
// Ports
//   clk, rst                       clock, async active-low reset
//   aw_valid/aw_payload/aw_tgtid   AW single-flit request in
//   aw_ready                       AW accepted this cycle
//   w_valid/w_head/w_tail/
//   w_payload/w_tgtid              W flit in, with packet delimiters
//   w_ready                        W accepted this cycle
//   ar_valid/ar_payload/ar_tgtid   AR single-flit request in
//   ar_ready                       AR accepted this cycle
//   o_valid/o_head/o_tail/
//   o_payload/o_tgtid/o_chan       registered flit to router (chan 00 AW, 01 W, 10 AR)
//   o_ready                        router accepts the flit on o_*
//   err                            sticky W framing error
module rn_inject_arb #(
    parameter int PW = 82,
    parameter int TW = 2,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          aw_valid,
    input  logic [PW-1:0] aw_payload,
    input  logic [TW-1:0] aw_tgtid,
    output logic          aw_ready,
    input  logic          w_valid,
    input  logic          w_head,
    input  logic          w_tail,
    input  logic [PW-1:0] w_payload,
    input  logic [TW-1:0] w_tgtid,
    output logic          w_ready,
    input  logic          ar_valid,
    input  logic [PW-1:0] ar_payload,
    input  logic [TW-1:0] ar_tgtid,
    output logic          ar_ready,
    output logic          o_valid,
    output logic          o_head,
    output logic          o_tail,
    output logic [PW-1:0] o_payload,
    output logic [TW-1:0] o_tgtid,
    output logic [1:0]    o_chan,
    input  logic          o_ready,
    output logic          err
);

    typedef enum logic {IDLE = 1'b0, WLOCK = 1'b1} state_t;

    localparam logic [1:0]    CH_AW   = 2'b00;
    localparam logic [1:0]    CH_W    = 2'b01;
    localparam logic [1:0]    CH_AR   = 2'b10;
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    ptr;
    logic [CW-1:0] awcnt;
    logic          slot_free;
    logic          aw_elig;
    logic          w_elig;
    logic          ar_elig;
    logic [2:0]    gnt;          // {ar, w, aw}

    assign slot_free = !o_valid || o_ready;

    always_comb begin
        aw_elig = 1'b0;
        w_elig  = 1'b0;
        ar_elig = 1'b0;
        if (state == WLOCK) begin
            w_elig = w_valid;
        end else begin
            aw_elig = aw_valid && (awcnt != CNT_MAX);
            w_elig  = w_valid && w_head && (awcnt != '0);
            ar_elig = ar_valid;
        end
    end

    // Priority rotates with ptr; in WLOCK only w_elig can be set, so the
    // same search yields the W-only behaviour without a separate path.
    always_comb begin
        gnt = 3'b000;
        case (ptr)
            CH_AW: begin
                if (aw_elig)      gnt = 3'b001;
                else if (w_elig)  gnt = 3'b010;
                else if (ar_elig) gnt = 3'b100;
            end
            CH_W: begin
                if (w_elig)       gnt = 3'b010;
                else if (ar_elig) gnt = 3'b100;
                else if (aw_elig) gnt = 3'b001;
            end
            default: begin
                if (ar_elig)      gnt = 3'b100;
                else if (aw_elig) gnt = 3'b001;
                else if (w_elig)  gnt = 3'b010;
            end
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (w_ready && !w_tail) state_nxt = WLOCK;
            WLOCK:   if (w_ready && w_tail)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. rst gates the readies so nothing handshakes while the
    // block is held in reset.
    always_comb begin
        aw_ready = gnt[0] && slot_free && rst;
        w_ready  = gnt[1] && slot_free && rst;
        ar_ready = gnt[2] && slot_free && rst;
    end

    // Round-robin pointer, outstanding-AW counter and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= CH_AW;
            awcnt <= '0;
            err   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (aw_ready)      ptr <= CH_W;
                else if (w_ready)  ptr <= CH_AR;
                else if (ar_ready) ptr <= CH_AW;
            end
            if (aw_ready) begin
                awcnt <= awcnt + 1'b1;
            end else if (w_ready && state == IDLE) begin
                awcnt <= awcnt - 1'b1;
            end
            if ((state == IDLE && w_valid && !w_head) ||
                (state == WLOCK && w_ready && w_head)) begin
                err <= 1'b1;
            end
        end
    end

    // Single-entry output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid   <= 1'b0;
            o_head    <= 1'b0;
            o_tail    <= 1'b0;
            o_payload <= '0;
            o_tgtid   <= '0;
            o_chan    <= CH_AW;
        end else if (aw_ready) begin
            o_valid   <= 1'b1;
            o_head    <= 1'b1;
            o_tail    <= 1'b1;
            o_payload <= aw_payload;
            o_tgtid   <= aw_tgtid;
            o_chan    <= CH_AW;
        end else if (w_ready) begin
            o_valid   <= 1'b1;
            o_head    <= w_head;
            o_tail    <= w_tail;
            o_payload <= w_payload;
            o_tgtid   <= w_tgtid;
            o_chan    <= CH_W;
        end else if (ar_ready) begin
            o_valid   <= 1'b1;
            o_head    <= 1'b1;
            o_tail    <= 1'b1;
            o_payload <= ar_payload;
            o_tgtid   <= ar_tgtid;
            o_chan    <= CH_AR;
        end else if (o_ready) begin
            o_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rn_inject_arb.sv
module tb_rn_inject_arb;

    localparam int PW = 82;
    localparam int TW = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          aw_valid = 1'b0;
    logic [PW-1:0] aw_payload = '0;
    logic [TW-1:0] aw_tgtid = '0;
    logic          aw_ready;
    logic          w_valid = 1'b0;
    logic          w_head = 1'b0;
    logic          w_tail = 1'b0;
    logic [PW-1:0] w_payload = '0;
    logic [TW-1:0] w_tgtid = '0;
    logic          w_ready;
    logic          ar_valid = 1'b0;
    logic [PW-1:0] ar_payload = '0;
    logic [TW-1:0] ar_tgtid = '0;
    logic          ar_ready;
    logic          o_valid;
    logic          o_head;
    logic          o_tail;
    logic [PW-1:0] o_payload;
    logic [TW-1:0] o_tgtid;
    logic [1:0]    o_chan;
    logic          o_ready = 1'b0;
    logic          err;

    int checks = 0;
    int errors = 0;

    rn_inject_arb #(.PW(PW), .TW(TW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .aw_valid(aw_valid), .aw_payload(aw_payload), .aw_tgtid(aw_tgtid), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_head(w_head), .w_tail(w_tail), .w_payload(w_payload),
        .w_tgtid(w_tgtid), .w_ready(w_ready),
        .ar_valid(ar_valid), .ar_payload(ar_payload), .ar_tgtid(ar_tgtid), .ar_ready(ar_ready),
        .o_valid(o_valid), .o_head(o_head), .o_tail(o_tail), .o_payload(o_payload),
        .o_tgtid(o_tgtid), .o_chan(o_chan), .o_ready(o_ready), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: channel index 0=AW 1=W 2=AR, plain integers.
    int            m_cnt;
    int            m_ptr;
    bit            m_lock;
    bit            m_err;
    bit            m_ov;
    bit            m_head;
    bit            m_tail;
    logic [1:0]    m_chan;
    logic [PW-1:0] m_pay;
    logic [TW-1:0] m_tgt;

    function automatic void m_reset();
        m_cnt = 0; m_ptr = 0; m_lock = 0; m_err = 0; m_ov = 0;
        m_head = 0; m_tail = 0; m_chan = 2'b00; m_pay = '0; m_tgt = '0;
    endfunction

    function automatic int model_grant();
        bit el [3];
        int c;
        if (!rst) return -1;
        if (m_ov && !o_ready) return -1;
        if (m_lock) return w_valid ? 1 : -1;
        el[0] = aw_valid && (m_cnt < (1 << CW) - 1);
        el[1] = w_valid && w_head && (m_cnt > 0);
        el[2] = ar_valid;
        for (int k = 0; k < 3; k++) begin
            c = (m_ptr + k) % 3;
            if (el[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_clock(int g);
        if (!m_lock && w_valid && !w_head) m_err = 1;
        if (m_lock && g == 1 && w_head) m_err = 1;
        if (g >= 0) begin
            m_ov = 1;
            m_chan = 2'(g);
            case (g)
                0: begin m_pay = aw_payload; m_tgt = aw_tgtid; m_head = 1; m_tail = 1; end
                1: begin m_pay = w_payload;  m_tgt = w_tgtid;  m_head = w_head; m_tail = w_tail; end
                default: begin m_pay = ar_payload; m_tgt = ar_tgtid; m_head = 1; m_tail = 1; end
            endcase
            if (g == 0) m_cnt++;
            if (g == 1 && !m_lock) m_cnt--;
            if (!m_lock) begin
                m_ptr = (g + 1) % 3;
                if (g == 1 && !w_tail) m_lock = 1;
            end else if (g == 1 && w_tail) begin
                m_lock = 0;
            end
        end else if (o_ready) begin
            m_ov = 0;
        end
    endfunction

    function automatic logic [PW-1:0] rand_pay();
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < PW; i += 16) p = (p << 16) | PW'($urandom_range(0, 65535));
        return p;
    endfunction

    // Stimulus helpers (drive only).
    task automatic idle_inputs();
        aw_valid = 0; w_valid = 0; ar_valid = 0; w_head = 0; w_tail = 0;
    endtask

    task automatic drive_aw(input logic [TW-1:0] t);
        aw_valid = 1; aw_payload = rand_pay(); aw_tgtid = t;
    endtask

    task automatic drive_w(input logic h, input logic tl, input logic [TW-1:0] t);
        w_valid = 1; w_head = h; w_tail = tl; w_payload = rand_pay(); w_tgtid = t;
    endtask

    task automatic drive_ar(input logic [TW-1:0] t);
        ar_valid = 1; ar_payload = rand_pay(); ar_tgtid = t;
    endtask

    // One clock: model follows the DUT's edge, returns at the next negedge.
    task automatic advance();
        int g;
        g = model_grant();
        @(posedge clk);
        model_clock(g);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 0;
        drive_aw(2'd1); drive_w(1, 1, 2'd2); drive_ar(2'd3); o_ready = 1;
        @(negedge clk); #1;
        checks++;
        if (o_valid !== 0 || o_head !== 0 || o_tail !== 0 || o_payload !== '0 ||
            o_tgtid !== '0 || o_chan !== 2'b00 || err !== 0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b h=%b t=%b tgt=%0d ch=%0d err=%b want all 0",
                     o_valid, o_head, o_tail, o_tgtid, o_chan, err);
        end
        checks++;
        if ({ar_ready, w_ready, aw_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_readies got %b want 000", {ar_ready, w_ready, aw_ready});
        end
        @(negedge clk);
        idle_inputs();
        rst = 1;
        m_reset();
    endtask

    task automatic test_aw_w_packet();
        int exp_ch [5] = '{0, 1, 1, 1, 1};
        bit exp_h  [5] = '{1, 1, 0, 0, 0};
        bit exp_t  [5] = '{1, 0, 0, 0, 1};
        o_ready = 1;
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            if (i == 0) drive_aw(2'd2);
            else drive_w(i == 1, i == 4, 2'd2);
            #1;
            checks++;
            if ({ar_ready, w_ready, aw_ready} !== 3'(1 << exp_ch[i])) begin
                errors++;
                $display("FAIL awpkt_ready flit%0d got %b want %b", i,
                         {ar_ready, w_ready, aw_ready}, 3'(1 << exp_ch[i]));
            end
            advance();
            checks++;
            if (o_valid !== 1 || o_chan !== 2'(exp_ch[i]) || o_head !== exp_h[i] ||
                o_tail !== exp_t[i] || o_tgtid !== 2'd2 || o_payload !== m_pay) begin
                errors++;
                $display("FAIL awpkt_out flit%0d got v=%b ch=%0d h=%b t=%b tgt=%0d want v=1 ch=%0d h=%b t=%b tgt=2",
                         i, o_valid, o_chan, o_head, o_tail, o_tgtid, exp_ch[i], exp_h[i], exp_t[i]);
            end
        end
        idle_inputs();
        advance();
        checks++;
        if (o_valid !== 0) begin
            errors++;
            $display("FAIL awpkt_drain got o_valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_w_blocked();
        o_ready = 1;
        idle_inputs();
        drive_w(1, 1, 2'd1);
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (w_ready !== 0 || err !== 0) begin
                errors++;
                $display("FAIL wblock_wait cyc%0d got w_ready=%b err=%b want 0 0", i, w_ready, err);
            end
            advance();
        end
        drive_aw(2'd0);
        #1;
        checks++;
        if (aw_ready !== 1 || w_ready !== 0) begin
            errors++;
            $display("FAIL wblock_aw got aw_ready=%b w_ready=%b want 1 0", aw_ready, w_ready);
        end
        advance();
        aw_valid = 0;
        #1;
        checks++;
        if (w_ready !== 1) begin
            errors++;
            $display("FAIL wblock_release got w_ready=%b want 1", w_ready);
        end
        advance();
        checks++;
        if (o_valid !== 1 || o_chan !== 2'b01 || o_head !== 1 || o_tail !== 1) begin
            errors++;
            $display("FAIL wblock_out got v=%b ch=%0d h=%b t=%b want 1 1 1 1", o_valid, o_chan, o_head, o_tail);
        end
    endtask

    task automatic test_rr_order();
        int exp_g [9] = '{2, 0, 1, 2, 0, 1, 2, 0, 1};
        int got;
        o_ready = 1;
        for (int i = 0; i < 9; i++) begin
            drive_aw(2'(i)); drive_w(1, 1, 2'(i + 1)); drive_ar(2'(i + 2));
            #1;
            got = aw_ready ? 0 : w_ready ? 1 : ar_ready ? 2 : -1;
            checks++;
            if (got !== exp_g[i] || ({ar_ready, w_ready, aw_ready} !== 3'(1 << exp_g[i]))) begin
                errors++;
                $display("FAIL rr_grant step%0d got readies %b want %b", i,
                         {ar_ready, w_ready, aw_ready}, 3'(1 << exp_g[i]));
            end
            advance();
            checks++;
            if (o_valid !== 1 || o_chan !== 2'(exp_g[i]) || o_payload !== m_pay) begin
                errors++;
                $display("FAIL rr_out step%0d got v=%b ch=%0d want v=1 ch=%0d", i, o_valid, o_chan, exp_g[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        logic [PW-1:0] head_pay;
        o_ready = 1;
        idle_inputs();
        drive_aw(2'd3);
        #1;
        checks++;
        if (aw_ready !== 1) begin
            errors++;
            $display("FAIL stall_aw got aw_ready=%b want 1", aw_ready);
        end
        advance();
        idle_inputs();
        drive_w(1, 0, 2'd3);
        head_pay = w_payload;
        #1;
        checks++;
        if (w_ready !== 1) begin
            errors++;
            $display("FAIL stall_whead got w_ready=%b want 1", w_ready);
        end
        advance();
        o_ready = 0;
        drive_w(0, 0, 2'd3);
        drive_ar(2'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (w_ready !== 0 || ar_ready !== 0) begin
                errors++;
                $display("FAIL stall_readies cyc%0d got w=%b ar=%b want 0 0", i, w_ready, ar_ready);
            end
            advance();
            checks++;
            if (o_valid !== 1 || o_chan !== 2'b01 || o_head !== 1 || o_tail !== 0 ||
                o_tgtid !== 2'd3 || o_payload !== head_pay) begin
                errors++;
                $display("FAIL stall_hold cyc%0d got v=%b ch=%0d h=%b t=%b tgt=%0d want 1 1 1 0 3",
                         i, o_valid, o_chan, o_head, o_tail, o_tgtid);
            end
        end
        o_ready = 1;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) drive_w(0, 1, 2'd3);
            #1;
            checks++;
            if (w_ready !== 1 || ar_ready !== 0) begin
                errors++;
                $display("FAIL stall_body flit%0d got w=%b ar=%b want 1 0", i + 2, w_ready, ar_ready);
            end
            advance();
            checks++;
            if (o_valid !== 1 || o_chan !== 2'b01 || o_tail !== (i == 1) || o_payload !== m_pay) begin
                errors++;
                $display("FAIL stall_bodyout flit%0d got v=%b ch=%0d t=%b", i + 2, o_valid, o_chan, o_tail);
            end
        end
        w_valid = 0;
        #1;
        checks++;
        if (ar_ready !== 1) begin
            errors++;
            $display("FAIL stall_ar got ar_ready=%b want 1", ar_ready);
        end
        advance();
        checks++;
        if (o_valid !== 1 || o_chan !== 2'b10 || o_tgtid !== 2'd1) begin
            errors++;
            $display("FAIL stall_arout got v=%b ch=%0d tgt=%0d want 1 2 1", o_valid, o_chan, o_tgtid);
        end
        idle_inputs();
    endtask

    task automatic test_awcnt_limit();
        o_ready = 1;
        idle_inputs();
        for (int i = 0; i < 15; i++) begin
            drive_aw(2'(i));
            #1;
            checks++;
            if (aw_ready !== 1) begin
                errors++;
                $display("FAIL awcnt_fill n=%0d got aw_ready=%b want 1", i, aw_ready);
            end
            advance();
        end
        #1;
        checks++;
        if (aw_ready !== 0) begin
            errors++;
            $display("FAIL awcnt_full got aw_ready=%b want 0", aw_ready);
        end
        advance();
        drive_w(1, 1, 2'd0);
        #1;
        checks++;
        if (w_ready !== 1 || aw_ready !== 0) begin
            errors++;
            $display("FAIL awcnt_wdec got w=%b aw=%b want 1 0", w_ready, aw_ready);
        end
        advance();
        w_valid = 0;
        #1;
        checks++;
        if (aw_ready !== 1) begin
            errors++;
            $display("FAIL awcnt_refill got aw_ready=%b want 1", aw_ready);
        end
        advance();
        idle_inputs();
        advance();
    endtask

    task automatic test_err();
        o_ready = 1;
        idle_inputs();
        drive_w(0, 0, 2'd2);
        #1;
        checks++;
        if (w_ready !== 0 || err !== 0) begin
            errors++;
            $display("FAIL err_body got w_ready=%b err=%b want 0 0", w_ready, err);
        end
        advance();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (err !== 1) begin
                errors++;
                $display("FAIL err_sticky cyc%0d got err=%b want 1", i, err);
            end
            advance();
        end
    endtask

    task automatic test_reset_midpacket();
        o_ready = 0;
        idle_inputs();
        drive_w(1, 0, 2'd1);
        #1;
        checks++;
        if (w_ready !== 1) begin
            errors++;
            $display("FAIL rstmid_head got w_ready=%b want 1", w_ready);
        end
        advance();
        drive_w(0, 0, 2'd1);
        checks++;
        if (o_valid !== 1) begin
            errors++;
            $display("FAIL rstmid_locked got o_valid=%b want 1", o_valid);
        end
        #2;
        rst = 0;
        #1;
        checks++;
        if (o_valid !== 0 || err !== 0 || {ar_ready, w_ready, aw_ready} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_async got v=%b err=%b rdy=%b want 0 0 000",
                     o_valid, err, {ar_ready, w_ready, aw_ready});
        end
        m_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        o_ready = 1;
        drive_ar(2'd2);
        #1;
        checks++;
        if (ar_ready !== 1) begin
            errors++;
            $display("FAIL rstmid_ar got ar_ready=%b want 1", ar_ready);
        end
        advance();
        ar_valid = 0;
        checks++;
        if (o_valid !== 1 || o_chan !== 2'b10 || o_head !== 1 || o_tail !== 1 ||
            o_tgtid !== 2'd2 || o_payload !== m_pay) begin
            errors++;
            $display("FAIL rstmid_arout got v=%b ch=%0d h=%b t=%b tgt=%0d want 1 2 1 1 2",
                     o_valid, o_chan, o_head, o_tail, o_tgtid);
        end
        advance();
        checks++;
        if (o_valid !== 0) begin
            errors++;
            $display("FAIL rstmid_nopartial got o_valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_random();
        int g;
        int pa, pw, pr;
        logic [2:0] exp_rdy;
        idle_inputs();
        rst = 0;
        @(negedge clk);
        rst = 1;
        m_reset();
        for (int n = 0; n < 600; n++) begin
            if (n < 300) begin pa = 50; pw = 60; pr = 40; end
            else begin pa = 95; pw = 10; pr = 20; end
            aw_valid = ($urandom_range(0, 99) < pa);
            aw_payload = rand_pay(); aw_tgtid = TW'($urandom_range(0, 3));
            ar_valid = ($urandom_range(0, 99) < pr);
            ar_payload = rand_pay(); ar_tgtid = TW'($urandom_range(0, 3));
            w_valid = ($urandom_range(0, 99) < pw);
            if (m_lock) w_head = ($urandom_range(0, 19) == 0);
            else w_head = ($urandom_range(0, 19) != 0);
            w_tail = 1'($urandom_range(0, 1));
            w_payload = rand_pay(); w_tgtid = TW'($urandom_range(0, 3));
            o_ready = ($urandom_range(0, 99) < 75);
            #1;
            g = model_grant();
            exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
            checks++;
            if ({ar_ready, w_ready, aw_ready} !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready cyc%0d got %b want %b", n, {ar_ready, w_ready, aw_ready}, exp_rdy);
            end
            advance();
            checks++;
            if (o_valid !== m_ov || err !== m_err ||
                (m_ov && (o_chan !== m_chan || o_head !== m_head || o_tail !== m_tail ||
                          o_payload !== m_pay || o_tgtid !== m_tgt))) begin
                errors++;
                $display("FAIL rand_out cyc%0d got v=%b ch=%0d h=%b t=%b tgt=%0d err=%b want v=%b ch=%0d h=%b t=%b tgt=%0d err=%b",
                         n, o_valid, o_chan, o_head, o_tail, o_tgtid, err,
                         m_ov, m_chan, m_head, m_tail, m_tgt, m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        test_reset();
        test_aw_w_packet();
        test_w_blocked();
        test_rr_order();
        test_stall();
        test_awcnt_limit();
        test_err();
        test_reset_midpacket();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
